uart_tx: RTL and testbench

- 8N1 UART transmitter, the outgoing counterpart of the existing UART receiver used by the ICCM programmer path.
- Accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them LSB-first on a single line.
- Bit timing is set by a runtime clocks-per-bit input, so the same baud setting used by the receiver can drive it.
- Intended for a host-visible console/echo channel and as loopback stimulus for the receiver.

---
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of it.
// Bytes enter through a valid/ready handshake and go out LSB-first on tx_o.
// The bit period is taken from clks_per_bit_i at the start of each frame.
//
// Handshake: a byte is accepted at a rising edge where tx_valid_i && tx_ready_o.
// tx_ready_o depends only on the registered FIFO occupancy (high when not full),
// so a pop in the same cycle never raises ready while the FIFO is full.
// tx_byte_i is ignored in cycles without an accepted push.
module uart_tx #(
    parameter int FifoDepth = 4,
    parameter int CpbWidth  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CpbWidth-1:0]          clks_per_bit_i,
    input  logic                         tx_valid_i,
    input  logic [7:0]                   tx_byte_i,
    output logic                         tx_ready_o,
    output logic                         tx_o,
    output logic                         tx_busy_o,
    output logic                         tx_done_o,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic [1:0]                   dbg_state_o
);

    localparam int AW = $clog2(FifoDepth);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FifoDepth);
    localparam logic [CpbWidth-1:0] MIN_CPB = CpbWidth'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FifoDepth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    // Serialiser state
    state_t              state_q, state_d;
    logic [CpbWidth-1:0] cnt_q, cnt_d;
    logic [CpbWidth-1:0] n_q, n_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done;
    logic                bit_end;
    logic [CpbWidth-1:0] eff_cpb;

    assign full    = (count_q == DEPTH_L);
    assign empty   = (count_q == '0);
    assign push    = tx_valid_i && !full;
    // Periods below 2 clocks are clamped so every bit lasts at least 2 cycles.
    assign eff_cpb = (clks_per_bit_i < MIN_CPB) ? MIN_CPB : clks_per_bit_i;
    assign bit_end = (cnt_q == n_q - CpbWidth'(1));

    // FIFO occupancy: push and pop together leave the level unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and level; pointers wrap naturally at FifoDepth
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // FIFO data array, written on an accepted push
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= tx_byte_i;
    end

    // Next-state logic: frame sequencing, bit timing and pops from the FIFO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    n_d     = eff_cpb;
                    cnt_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CpbWidth'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CpbWidth'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    done  = 1'b1;
                    cnt_d = '0;
                    // A waiting byte starts immediately: no idle gap between frames.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        n_d     = eff_cpb;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CpbWidth'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serialiser registers; reset aborts any frame and parks the line high
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= MIN_CPB;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign tx_ready_o   = !full;
    assign tx_busy_o    = (state_q != IDLE);
    assign tx_done_o    = done;
    assign fifo_level_o = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Outputs are sampled on the falling
// clock edge; inputs are driven on the falling edge as well.
module tb_uart_tx;

    logic        clock;
    logic        reset;
    logic [15:0] clks_per_bit_i;
    logic        tx_valid_i;
    logic [7:0]  tx_byte_i;
    logic        tx_ready_o;
    logic        tx_o;
    logic        tx_busy_o;
    logic        tx_done_o;
    logic [2:0]  fifo_level_o;
    logic [1:0]  dbg_state_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [7:0] pbytes [8];
    logic [7:0] exp_q [$];
    logic       saw_full;
    int         ready_errs;

    uart_tx #(.FifoDepth(4), .CpbWidth(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .clks_per_bit_i (clks_per_bit_i),
        .tx_valid_i     (tx_valid_i),
        .tx_byte_i      (tx_byte_i),
        .tx_ready_o     (tx_ready_o),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .tx_done_o      (tx_done_o),
        .fifo_level_o   (fifo_level_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        tx_valid_i = 1'b0;
        tx_byte_i  = 8'h00;
        reset      = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Offer pbytes[0..n-1] with valid held high; a byte advances when ready was high.
    task automatic push_list(input int n, input int budget);
        int idx = 0;
        int cyc = 0;
        logic r;
        while (idx < n && cyc < budget) begin
            tx_byte_i  = pbytes[idx];
            tx_valid_i = 1'b1;
            r = tx_ready_o;
            if (fifo_level_o == 3'd4) saw_full = 1'b1;
            if (tx_ready_o !== (fifo_level_o != 3'd4)) ready_errs++;
            @(negedge clock);
            if (r) idx++;
            cyc++;
        end
        tx_valid_i = 1'b0;
        check_eq("pushes accepted", idx, n);
    endtask

    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (tx_o !== 1'b0 && waited < budget) begin
            @(negedge clock);
            waited++;
        end
        check_eq("start bit seen", {31'd0, tx_o}, 32'd0);
    endtask

    // Called in cycle 1 of a frame; checks 10*n cycles of line, busy and done.
    task automatic expect_frame(input int n);
        logic [7:0] b;
        logic [7:0] rx = 8'h00;
        logic       e;
        int errs = 0, dones = 0, done_at = 0, bp;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard empty", 1, 0);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        for (int c = 1; c <= 10 * n; c++) begin
            bp = (c - 1) / n;
            if (bp == 0)      e = 1'b0;
            else if (bp == 9) e = 1'b1;
            else              e = b[bp-1];
            if (tx_o !== e) errs++;
            if (tx_busy_o !== 1'b1) errs++;
            if ((c - 1) % n == n / 2 && bp >= 1 && bp <= 8) rx[bp-1] = tx_o;
            if (tx_done_o === 1'b1) begin
                dones++;
                done_at = c;
            end
            @(negedge clock);
        end
        check_eq("frame line errors", errs, 0);
        check_eq("frame byte", {24'd0, rx}, {24'd0, b});
        check_eq("done pulses", dones, 1);
        check_eq("done position", done_at, 10 * n);
    endtask

    initial begin
        int w, errs;
        int found;
        reset          = 1'b1;
        tx_valid_i     = 1'b0;
        tx_byte_i      = 8'h00;
        clks_per_bit_i = 16'd4;
        saw_full       = 1'b0;
        ready_errs     = 0;

        // reset values, then 50 idle cycles
        repeat (3) @(negedge clock);
        check_eq("reset tx_o", {31'd0, tx_o}, 1);
        check_eq("reset busy", {31'd0, tx_busy_o}, 0);
        check_eq("reset done", {31'd0, tx_done_o}, 0);
        check_eq("reset level", {29'd0, fifo_level_o}, 0);
        check_eq("reset ready", {31'd0, tx_ready_o}, 1);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_ready_o !== 1'b1 ||
                fifo_level_o !== 3'd0 || tx_done_o !== 1'b0) errs++;
        end
        check_eq("idle errors", errs, 0);

        // single byte 0xA5 at N=4: line 0 | 1,0,1,0,0,1,0,1 | 1
        pbytes[0] = 8'hA5;
        exp_q = '{8'hA5};
        push_list(1, 10);
        check_eq("level after push", {29'd0, fifo_level_o}, 1);
        check_eq("line idle before start", {31'd0, tx_o}, 1);
        wait_start(10, w);
        check_eq("start latency", w, 1);
        expect_frame(4);
        check_eq("idle after frame tx", {31'd0, tx_o}, 1);
        check_eq("idle after frame busy", {31'd0, tx_busy_o}, 0);

        // six bytes, valid held high, back-to-back frames
        do_reset();
        saw_full = 1'b0;
        ready_errs = 0;
        for (int i = 0; i < 6; i++) pbytes[i] = 8'(i + 1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fork
            push_list(6, 500);
            begin
                wait_start(10, w);
                repeat (6) expect_frame(4);
            end
        join
        check_eq("saw level 4", {31'd0, saw_full}, 1);
        check_eq("ready vs full", ready_errs, 0);
        check_eq("idle after burst", {31'd0, tx_busy_o}, 0);
        check_eq("level after burst", {29'd0, fifo_level_o}, 0);

        // simultaneous push and pop at level 2
        do_reset();
        pbytes[0] = 8'h11; pbytes[1] = 8'h22; pbytes[2] = 8'h33;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fork
            push_list(3, 20);
            begin
                wait_start(10, w);
                repeat (4) expect_frame(4);
            end
            begin
                found = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clock);
                    if (tx_done_o === 1'b1) begin
                        found = 1;
                        break;
                    end
                end
                check_eq("first done seen", found, 1);
                check_eq("level before push+pop", {29'd0, fifo_level_o}, 2);
                tx_byte_i  = 8'h44;
                tx_valid_i = 1'b1;
                @(negedge clock);
                tx_valid_i = 1'b0;
                check_eq("level after push+pop", {29'd0, fifo_level_o}, 2);
            end
        join

        // clks_per_bit 0 and 1 are clamped to 2
        do_reset();
        clks_per_bit_i = 16'd0;
        pbytes[0] = 8'h3C;
        exp_q = '{8'h3C};
        push_list(1, 10);
        wait_start(10, w);
        expect_frame(2);
        clks_per_bit_i = 16'd1;
        pbytes[0] = 8'hC3;
        exp_q = '{8'hC3};
        push_list(1, 10);
        wait_start(10, w);
        expect_frame(2);

        // change 4 -> 8 mid-frame: current frame 40 cycles, next 80
        do_reset();
        clks_per_bit_i = 16'd4;
        pbytes[0] = 8'h5A; pbytes[1] = 8'h96;
        exp_q = '{8'h5A, 8'h96};
        push_list(2, 10);
        fork
            begin
                wait_start(10, w);
                expect_frame(4);
                expect_frame(8);
            end
            begin
                repeat (10) @(negedge clock);
                clks_per_bit_i = 16'd8;
            end
        join
        clks_per_bit_i = 16'd4;

        // reset during DATA bit 3 with two bytes queued
        do_reset();
        pbytes[0] = 8'hF0; pbytes[1] = 8'h0F; pbytes[2] = 8'h81;
        fork
            push_list(3, 20);
            begin
                wait_start(10, w);
                repeat (17) @(negedge clock);
            end
        join
        check_eq("level in bit 3", {29'd0, fifo_level_o}, 2);
        check_eq("line in bit 3", {31'd0, tx_o}, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort tx_o", {31'd0, tx_o}, 1);
        check_eq("abort level", {29'd0, fifo_level_o}, 0);
        check_eq("abort busy", {31'd0, tx_busy_o}, 0);
        check_eq("abort ready", {31'd0, tx_ready_o}, 1);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_o !== 1'b1 || tx_done_o !== 1'b0 || tx_busy_o !== 1'b0 ||
                fifo_level_o !== 3'd0) errs++;
        end
        check_eq("quiet after abort", errs, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
